emotion_tracker: RTL and testbench

//  Parametrised, sequential successor to the combinational emotion mapper.
//  - Quantises energy, stress and pleasure (LEVEL_W bits each) into LOW/OK/HIGH using programmable thresholds.
//  - Derives a candidate emotion vector and commits it only after it has been stable for HOLD_CYCLES (debounce).
//  - Forces neutral output while not awake; sits between the drive/state registers and the behaviour/output logic.

---
 rtl/emotion_pkg.sv | 46 ++++
 rtl/emotion_tracker_level_quantizer.sv | 33 +++
 rtl/emotion_tracker.sv | 137 +++++++++++++
 tb/tb_emotion_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/emotion_pkg.sv
// Shared definitions for the emotion tracker.
//  - Level codes produced by level_quantizer (LOW / OK / HIGH).
//  - AWAKE_CODE: physical_state value meaning "awake".
//  - EMO_* : bit positions within the 8-bit emotion vector.
//  - emo_candidate(): maps three level codes to a candidate emotion vector.
package emotion_pkg;

  typedef enum logic [1:0] {
    LVL_LOW  = 2'b00,
    LVL_OK   = 2'b01,
    LVL_HIGH = 2'b10
  } level_e;

  localparam logic [1:0] AWAKE_CODE = 2'b01;

  localparam int EMO_0 = 0;
  localparam int EMO_1 = 1;
  localparam int EMO_2 = 2;
  localparam int EMO_3 = 3;
  localparam int EMO_4 = 4;
  localparam int EMO_5 = 5;
  localparam int EMO_6 = 6;
  localparam int EMO_7 = 7;

  // Several bits may be set at once; an all-zero result is legal.
  function automatic logic [7:0] emo_candidate(input logic [1:0] e,
                                               input logic [1:0] s,
                                               input logic [1:0] p);
    logic eL, eO, eH, sL, sO, sH, pL, pO, pH;
    logic [7:0] c;
    eL = (e == LVL_LOW);  eO = (e == LVL_OK);  eH = (e == LVL_HIGH);
    sL = (s == LVL_LOW);  sO = (s == LVL_OK);  sH = (s == LVL_HIGH);
    pL = (p == LVL_LOW);  pO = (p == LVL_OK);  pH = (p == LVL_HIGH);
    c = '0;
    c[EMO_7] = sH & ((pH & eH) | pO);
    c[EMO_6] = ~pH & sO & eH;
    c[EMO_5] = pL & sH;
    c[EMO_4] = ~sH & eL;
    c[EMO_3] = pL & ((sL & eH) | (~sH & eO));
    c[EMO_2] = (pH & ~sH & eH) | (pH & sH & ~eH) | (pO & sL & eH);
    c[EMO_1] = pO & ~sH & eO;
    c[EMO_0] = pH & ~sH & eO;
    return c;
  endfunction

endpackage

// File: rtl/emotion_tracker_level_quantizer.sv
// level_quantizer: classifies one unsigned drive level into LOW / OK / HIGH.
//  Parameters: LEVEL_W (input width), LOW_TH, HIGH_TH (LOW_TH <= HIGH_TH).
//  Ports:
//    level  in  LEVEL_W  drive level
//    code   out 2        LVL_LOW if level < LOW_TH, LVL_HIGH if level >= HIGH_TH,
//                        LVL_OK otherwise
module level_quantizer
  import emotion_pkg::*;
#(
  parameter int LEVEL_W = 4,
  parameter int LOW_TH  = 4,
  parameter int HIGH_TH = 12
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [1:0]         code
);

  // Compare at 32 bits so thresholds equal to 2**LEVEL_W still behave.
  localparam logic [31:0] LOW_U  = LOW_TH;
  localparam logic [31:0] HIGH_U = HIGH_TH;

  logic [31:0] w_level;
  assign w_level = 32'(level);

  always_comb begin
    code = LVL_OK;
    if (w_level < LOW_U)
      code = LVL_LOW;
    else if (w_level >= HIGH_U)
      code = LVL_HIGH;
  end

endmodule

// File: rtl/emotion_tracker.sv
// emotion_tracker: debounced emotion vector derived from three drive levels.
//  Stage 1 registers the quantised levels and the awake flag; the candidate
//  emotion is decoded from stage 1 and committed only after it has persisted
//  for HOLD_CYCLES cycles. While not awake the output is forced to zero.
//  Optional feature macro: EMOTION_INTENSITY_EN (adds the intensity port).
//  Ports:
//    clk              in   1        system clock
//    rst              in   1        asynchronous active-high reset
//    energy           in   LEVEL_W  energy level
//    stress           in   LEVEL_W  stress level
//    pleasure         in   LEVEL_W  pleasure level
//    physical_state   in   2        AWAKE_CODE = awake
//    emotion          out  8        committed emotion vector
//    emotion_changed  out  1        pulse on the edge emotion changes value
//    intensity        out  4        cycles since last change, saturating at 15
//                                   (EMOTION_INTENSITY_EN only)
module emotion_tracker
  import emotion_pkg::*;
#(
  parameter int LEVEL_W     = 4,
  parameter int LOW_TH      = 4,
  parameter int HIGH_TH     = 12,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] energy,
  input  logic [LEVEL_W-1:0] stress,
  input  logic [LEVEL_W-1:0] pleasure,
  input  logic [1:0]         physical_state,
  output logic [7:0]         emotion,
  output logic               emotion_changed
`ifdef EMOTION_INTENSITY_EN
  ,
  output logic [3:0]         intensity
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);

  logic [1:0] w_e_code, w_s_code, w_p_code;

  level_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH))
    u_q_energy   (.level(energy),   .code(w_e_code));
  level_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH))
    u_q_stress   (.level(stress),   .code(w_s_code));
  level_quantizer #(.LEVEL_W(LEVEL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH))
    u_q_pleasure (.level(pleasure), .code(w_p_code));

  logic [1:0]       r_e_p1, r_s_p1, r_p_p1;
  logic             r_awake_p1;
  logic [7:0]       r_pend_p2, r_emo_p2;
  logic [CNT_W-1:0] r_cnt_p2;
  logic             r_chg_p2;

  logic [7:0]       w_cand;
  logic [7:0]       w_pend_nxt, w_emo_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_emo_change;

  // ---- stage 1: quantised levels and awake flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_p1     <= '0;
      r_s_p1     <= '0;
      r_p_p1     <= '0;
      r_awake_p1 <= 1'b0;
    end else begin
      r_e_p1     <= w_e_code;
      r_s_p1     <= w_s_code;
      r_p_p1     <= w_p_code;
      r_awake_p1 <= (physical_state == AWAKE_CODE);
    end
  end

  // ---- stage 2: debounce and commit ----
  // Sleep takes priority over a commit falling on the same edge. Once the
  // count saturates the pending value is re-committed every cycle, which is
  // harmless because emotion_changed only fires on an actual value change.
  always_comb begin
    w_cand     = emo_candidate(r_e_p1, r_s_p1, r_p_p1);
    w_pend_nxt = r_pend_p2;
    w_cnt_nxt  = r_cnt_p2;
    w_emo_nxt  = r_emo_p2;
    if (!r_awake_p1) begin
      w_pend_nxt = '0;
      w_cnt_nxt  = '0;
      w_emo_nxt  = '0;
    end else if (w_cand != r_pend_p2) begin
      w_pend_nxt = w_cand;
      w_cnt_nxt  = CNT_W'(1);
    end else if (r_cnt_p2 < HOLD_V) begin
      w_cnt_nxt  = r_cnt_p2 + CNT_W'(1);
    end else begin
      w_emo_nxt  = r_pend_p2;
    end
    w_emo_change = (w_emo_nxt != r_emo_p2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_p2 <= '0;
      r_cnt_p2  <= '0;
      r_emo_p2  <= '0;
      r_chg_p2  <= 1'b0;
    end else begin
      r_pend_p2 <= w_pend_nxt;
      r_cnt_p2  <= w_cnt_nxt;
      r_emo_p2  <= w_emo_nxt;
      r_chg_p2  <= w_emo_change;
    end
  end

  assign emotion         = r_emo_p2;
  assign emotion_changed = r_chg_p2;

`ifdef EMOTION_INTENSITY_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [3:0] r_int_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_int_p2 <= '0;
    else if (!r_awake_p1 || w_emo_change)
      r_int_p2 <= '0;
    else
      r_int_p2 <= sat_inc4(r_int_p2);
  end

  assign intensity = r_int_p2;
`endif

endmodule

// File: tb/tb_emotion_tracker.sv
module tb_emotion_tracker;

  localparam int LOW_TH  = 4;
  localparam int HIGH_TH = 12;
  localparam int HOLD    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] energy, stress, pleasure;
  logic [1:0] physical_state;
  logic [7:0] emotion;
  logic       chg;
`ifdef EMOTION_INTENSITY_EN
  logic [3:0] inten;
`endif

  emotion_tracker #(.LEVEL_W(4), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .energy(energy),
    .stress(stress),
    .pleasure(pleasure),
    .physical_state(physical_state),
    .emotion(emotion),
    .emotion_changed(chg)
`ifdef EMOTION_INTENSITY_EN
    ,
    .intensity(inten)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  // Reference model: the input seen one edge ago, how long the current
  // candidate has run while awake, and the committed outputs.
  logic [7:0] m_c1;
  bit         m_a1;
  int         m_last;
  int         m_run;
  logic [7:0] m_emo;
  bit         m_chg;
  int         m_int;

  typedef struct {
    int         e;
    int         s;
    int         p;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [7:0] ref_cand(input int e, input int s, input int p);
    bit eL, eO, eH, sL, sO, sH, pL, pO, pH;
    logic [7:0] c;
    eL = e < LOW_TH;  eH = e >= HIGH_TH;  eO = !eL && !eH;
    sL = s < LOW_TH;  sH = s >= HIGH_TH;  sO = !sL && !sH;
    pL = p < LOW_TH;  pH = p >= HIGH_TH;  pO = !pL && !pH;
    c[7] = sH && ((pH && eH) || pO);
    c[6] = !pH && sO && eH;
    c[5] = pL && sH;
    c[4] = !sH && eL;
    c[3] = pL && ((sL && eH) || (!sH && eO));
    c[2] = (pH && !sH && eH) || (pH && sH && !eH) || (pO && sL && eH);
    c[1] = pO && !sH && eO;
    c[0] = pH && !sH && eO;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c1 = '0; m_a1 = 0; m_last = -1; m_run = 0;
    m_emo = '0; m_chg = 0; m_int = 0;
  endtask

  task automatic model_edge();
    logic [7:0] prev;
    prev = m_emo;
    if (!m_a1) begin
      m_emo = '0; m_last = -1; m_run = 0;
    end else begin
      if (int'(m_c1) == m_last) begin
        if (m_run < HOLD + 1) m_run++;
      end else begin
        m_last = int'(m_c1);
        m_run  = 1;
      end
      if (m_run >= HOLD + 1) m_emo = m_c1;
    end
    m_chg = (m_emo != prev);
    if (!m_a1 || m_chg) m_int = 0;
    else if (m_int < 15) m_int++;
    m_c1 = ref_cand(int'(energy), int'(stress), int'(pleasure));
    m_a1 = (physical_state == 2'b01);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (chg === 1'b1) npulse++;
    check("emotion", 32'(emotion), 32'(m_emo));
    check("emotion_changed", 32'(chg), 32'(m_chg));
`ifdef EMOTION_INTENSITY_EN
    check("intensity", 32'(inten), 32'(m_int));
`endif
  endtask

  task automatic apply(input int e, input int s, input int p);
    energy = 4'(e); stress = 4'(s); pleasure = 4'(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_emotion", 32'(emotion), 32'h00);
    check("rst_changed", 32'(chg), 32'h0);
`ifdef EMOTION_INTENSITY_EN
    check("rst_intensity", 32'(inten), 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;
    tbl[0]  = '{0, 15, 0, 8'h20};
    tbl[1]  = '{8, 0, 8, 8'h02};
    tbl[2]  = '{15, 8, 8, 8'h40};
    tbl[3]  = '{0, 0, 0, 8'h10};
    tbl[4]  = '{15, 0, 0, 8'h08};
    tbl[5]  = '{8, 0, 15, 8'h01};
    tbl[6]  = '{15, 15, 15, 8'h80};
    tbl[7]  = '{0, 15, 15, 8'h04};
    tbl[8]  = '{8, 15, 8, 8'h80};
    tbl[9]  = '{8, 8, 8, 8'h02};
    tbl[10] = '{4, 3, 11, 8'h02};
    tbl[11] = '{12, 4, 3, 8'h40};
    tbl[12] = '{3, 11, 12, 8'h10};
    tbl[13] = '{8, 0, 0, 8'h08};

    apply(0, 0, 0);
    physical_state = 2'b01;
    do_reset();

    // Commit latency: new value on exactly the 10th edge, one pulse.
    apply(15, 0, 15);
    npulse = 0;
    repeat (HOLD + 1) tick();
    check("lat_before", 32'(emotion), 32'h00);
    tick();
    check("lat_commit", 32'(emotion), 32'h04);
    check("lat_pulse", 32'(chg), 32'h1);
    repeat (3) tick();
    check("lat_pulses", 32'(npulse), 32'd1);

    // Glitch shorter than the hold time is rejected.
    apply(8, 0, 8);
    npulse = 0;
    repeat (3) tick();
    apply(15, 0, 15);
    repeat (12) tick();
    check("glitch_emotion", 32'(emotion), 32'h04);
    check("glitch_pulses", 32'(npulse), 32'd0);

    // Table of level combinations, each held long enough to commit.
    prev = 8'h04;
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].e, tbl[i].s, tbl[i].p);
      npulse = 0;
      repeat (HOLD + 1) tick();
      check($sformatf("tbl%0d_hold", i), 32'(emotion), 32'(prev));
      tick();
      check($sformatf("tbl%0d_commit", i), 32'(emotion), 32'(tbl[i].exp));
      check($sformatf("tbl%0d_pulses", i), 32'(npulse), (tbl[i].exp != prev) ? 32'd1 : 32'd0);
      prev = tbl[i].exp;
    end

`ifdef EMOTION_INTENSITY_EN
    check("int_at_commit", 32'(inten), 32'd0);
    repeat (15) tick();
    check("int_reach15", 32'(inten), 32'd15);
    repeat (4) tick();
    check("int_hold15", 32'(inten), 32'd15);
`endif

    // Sleep forces neutral on the edge after awake drops; wake re-debounces.
    apply(0, 15, 0);
    repeat (HOLD + 2) tick();
    check("sleep_pre", 32'(emotion), 32'h20);
    physical_state = 2'b10;
    npulse = 0;
    tick();
    check("sleep_edge1", 32'(emotion), 32'h20);
    tick();
    check("sleep_edge2", 32'(emotion), 32'h00);
    check("sleep_pulse", 32'(chg), 32'h1);
    repeat (4) tick();
    check("sleep_pulses", 32'(npulse), 32'd1);
`ifdef EMOTION_INTENSITY_EN
    check("sleep_int", 32'(inten), 32'd0);
`endif
    physical_state = 2'b01;
    repeat (HOLD + 1) tick();
    check("wake_before", 32'(emotion), 32'h00);
    tick();
    check("wake_commit", 32'(emotion), 32'h20);

    // Reset mid-debounce clears at once; debounce restarts after release.
    apply(15, 0, 15);
    repeat (4) tick();
    do_reset();
    repeat (HOLD + 1) tick();
    check("rst_restart_before", 32'(emotion), 32'h00);
    tick();
    check("rst_restart_commit", 32'(emotion), 32'h04);

    // Randomised segments against the model.
    for (int k = 0; k < 300; k++) begin
      int len;
      apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      physical_state = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      len = int'($urandom_range(1, 12));
      repeat (len) tick();
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
